orion_video_reader: RTL
=======================

Name: orion_video_reader

Overview:
- Display-side reader of the Orion video RAM; the counterpart of the CPU write path into the 2 MB RAM array.
- Generates raster timing and fetches screen bytes through a request/acknowledge read port into the memory arbiter.
- Serialises pixels as 4-bit IRGB and emits a frame-end pulse for the CPU interrupt (FB int-enable gating is done outside this block).

Parameters:
H_ACTIVE, 384, active pixels per line (48 byte columns x 8)
H_TOTAL, 640, pixel clocks per line
HS_START, 424, first hsync pixel
HS_LEN, 56, hsync width in pixels
V_ACTIVE, 256, active lines
V_TOTAL, 312, lines per frame
VS_START, 270, first vsync line
VS_LEN, 4, vsync width in lines

Ports:
i_clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
i_pix_ce  in  1  pixel clock enable; all raster state advances only when high
i_scr_sel  in  2  screen base select: 0=C000, 1=8000, 2=4000, 3=0000
i_color_mode  in  1  1 = 16-colour (plane 1 = attribute), 0 = monochrome
o_rd_req  out  1  read request, held until ack
o_rd_addr  out  21  physical RAM byte address
i_rd_ack  in  1  one-cycle ack; i_rd_data valid in the same cycle
i_rd_data  in  8  read data
o_pix  out  4  IRGB pixel index
o_hsync  out  1  horizontal sync, active high
o_vsync  out  1  vertical sync, active high
o_de  out  1  active display area
o_frame_end  out  1  one-i_clk pulse at start of vertical blank
o_underrun  out  1  sticky, set when a pixel group was not fetched in time

Behaviour:
- Reset values: counters h=0, v=0; all outputs 0; FSM IDLE; fetch buffer empty.
- h counts 0..H_TOTAL-1 on i_pix_ce and wraps to 0, incrementing v. v wraps at V_TOTAL.
- o_de = (h<H_ACTIVE)&(v<V_ACTIVE).
- o_hsync = HS_START<=h<HS_START+HS_LEN.
- o_vsync = VS_START<=v<VS_START+VS_LEN.
- All raster outputs are registered, with one cycle of latency after the i_pix_ce edge.
- o_frame_end is high for exactly one i_clk, in the cycle after the i_pix_ce that moves to h=0, v=V_ACTIVE.
- Screen addressing is column-major. vaddr[15:0] = base + {fcol[5:0], frow[7:0]}, where base = (3-i_scr_sel)<<14.
- Plane 0 (pixels) address: o_rd_addr = {5'd0, vaddr}.
- Plane 1 (attribute) address: o_rd_addr = {5'd1, vaddr}.
- Fetch pointer:
  - At h==H_ACTIVE (any v): fcol<=0; frow<=(v+1 mod V_TOTAL)[7:0]; fetch enabled only if the next line is < V_ACTIVE.
  - fcol increments after each completed group. Fetching stops at fcol==48.
- Fetch FSM (advances every i_clk, independent of i_pix_ce):
  - IDLE -> RD_P0 when fetch enabled, fcol<48 and buffer empty.
  - RD_P0: o_rd_req=1, plane-0 address. On ack, latch byte and go to RD_P1 if i_color_mode, else mark buffer full and return to IDLE.
  - RD_P1: o_rd_req=1, plane-1 address. On ack, latch byte, mark buffer full, return to IDLE.
  - Address is stable while o_rd_req is high. Acks received in IDLE are ignored.
- Group load: on i_pix_ce with o_de-region h and h[2:0]==0:
  - If the buffer is full: shift register <= buffer, attribute register <= buffer attribute, buffer empty.
  - If the buffer is empty: load 0x00 pixels with attribute 0x00 and set o_underrun.
  - A buffer fill and a load in the same cycle: the load takes the new data.
- Pixel out: MSB first, one bit per i_pix_ce.
  - Colour mode: bit=1 -> attr[3:0]; bit=0 -> attr[7:4].
  - Mono mode: bit=1 -> 4'hF; bit=0 -> 4'h0.
  - o_pix = 0 when !o_de, unless VIDEO_BORDER_EN is defined.
- i_scr_sel and i_color_mode are sampled at h==H_ACTIVE only; changes take effect from the next line.
- Reset mid-fetch: o_rd_req drops in the cycle reset is sampled; the arbiter must discard the pending access.

Optional Feature:
- Macro ORION_VIDEO_BORDER_EN.
- Defined: extra input i_border[3:0]; outside o_de, o_pix = i_border. The value is sampled at h==0 of each line.
- Undefined: no i_border port; o_pix = 0 outside o_de.

Test Plan:
- Reset, i_pix_ce=1 continuously, ack after one cycle: o_hsync first rises at h=424; o_frame_end pulses once per 640*312 cycles; o_underrun stays 0.
- i_scr_sel=0, mono: first fetch of line 0 addresses 0x0C000, then 0x0C100. RAM[0x0C000]=0xA5 -> line 0 pixels 0..7 = F,0,F,0,0,F,0,F.
- Colour mode, plane1[0x1C005]=0x3C, plane0[0x0C005]=0xF0 -> line 5 pixels 0..3 = 0xC, pixels 4..7 = 0x3.
- Arbiter delays ack 20 cycles with i_pix_ce every 2 cycles -> group shows 0x0 and o_underrun=1 until reset.
- Change i_scr_sel 0->3 at mid-line h=100 -> current line continues from 0xCxxx; next line fetches from 0x0000 + col*256 + row.
- Assert reset_n=0 while in RD_P1 -> o_rd_req=0 next cycle, all outputs 0, and after release the first fetch restarts at fcol 0.

Source files
------------

// File: rtl/orion_video_reader.sv
// orion_video_reader: display-side reader of the Orion video RAM.
// Generates raster timing, fetches screen bytes (pixel plane and optional
// attribute plane) through a req/ack read port and serialises IRGB pixels.
// Optional build macro ORION_VIDEO_BORDER_EN adds i_border, which drives o_pix
// outside the active area (sampled at h==0 of each line).
//
// state | meaning
// IDLE  | waiting for an empty buffer and an enabled fetch pointer
// RD_P0 | reading the pixel byte (plane 0)
// RD_P1 | reading the attribute byte (plane 1), colour mode only
`timescale 1ns/1ps
module orion_video_reader #(
   parameter int H_ACTIVE = 384,
   parameter int H_TOTAL  = 640,
   parameter int HS_START = 424,
   parameter int HS_LEN   = 56,
   parameter int V_ACTIVE = 256,
   parameter int V_TOTAL  = 312,
   parameter int VS_START = 270,
   parameter int VS_LEN   = 4
) (
   input  logic        i_clk,
   input  logic        reset_n,
   input  logic        i_pix_ce,
   input  logic [1:0]  i_scr_sel,
   input  logic        i_color_mode,
`ifdef ORION_VIDEO_BORDER_EN
   input  logic [3:0]  i_border,
`endif
   output logic        o_rd_req,
   output logic [20:0] o_rd_addr,
   input  logic        i_rd_ack,
   input  logic [7:0]  i_rd_data,
   output logic [3:0]  o_pix,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic        o_frame_end,
   output logic        o_underrun
);
   localparam logic [9:0] HA_W    = 10'(H_ACTIVE);
   localparam logic [9:0] HT_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0] HS_S    = 10'(HS_START);
   localparam logic [9:0] HS_E    = 10'(HS_START + HS_LEN);
   localparam logic [8:0] VA_W    = 9'(V_ACTIVE);
   localparam logic [8:0] VA_LAST = 9'(V_ACTIVE - 1);
   localparam logic [8:0] VT_LAST = 9'(V_TOTAL - 1);
   localparam logic [8:0] VS_S    = 9'(VS_START);
   localparam logic [8:0] VS_E    = 9'(VS_START + VS_LEN);
   localparam logic [5:0] NCOL_W  = 6'(H_ACTIVE / 8);

   typedef enum logic [1:0] {IDLE, RD_P0, RD_P1} state_t;
   state_t state, state_nxt;

   logic [9:0]  h;
   logic [8:0]  v, v_nxt;
   logic        de_now, hs_now, vs_now, at_ha, grp_load;
   logic [5:0]  fcol;
   logic [7:0]  frow;
   logic        fetch_en, primed, color_line;
   logic [1:0]  scr_line;
   logic [15:0] vaddr_calc, vaddr_r;
   logic        fetch_start, fill_now;
   logic [7:0]  fill_pix, fill_attr, p0_r;
   logic        buf_full;
   logic [7:0]  buf_pix, buf_attr, ld_pix, ld_attr;
   logic [7:0]  shreg, attr_r, cur_byte, cur_attr;
   logic [3:0]  pix_val, border_val;

   assign v_nxt    = (v == VT_LAST) ? 9'd0 : v + 9'd1;
   assign de_now   = (h < HA_W) && (v < VA_W);
   assign hs_now   = (h >= HS_S) && (h < HS_E);
   assign vs_now   = (v >= VS_S) && (v < VS_E);
   assign at_ha    = i_pix_ce && (h == HA_W);
   // The first line after reset has no prefetched data, so group loads wait
   // until a line has been set up at h==H_ACTIVE.
   assign grp_load = i_pix_ce && de_now && (h[2:0] == 3'd0) && primed;
   assign vaddr_calc = {~scr_line, 14'd0} + {2'b00, fcol, frow};

   // Fetch FSM state register
   always_ff @(posedge i_clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Fetch FSM next state and read-port outputs
   always_comb begin
      state_nxt   = state;
      o_rd_req    = 1'b0;
      o_rd_addr   = {5'd0, vaddr_r};
      fetch_start = 1'b0;
      fill_now    = 1'b0;
      fill_pix    = i_rd_data;
      fill_attr   = 8'h00;
      case (state)
         IDLE: begin
            if (fetch_en && (fcol < NCOL_W) && !buf_full && !at_ha) begin
               fetch_start = 1'b1;
               state_nxt   = RD_P0;
            end
         end
         RD_P0: begin
            o_rd_req = 1'b1;
            if (i_rd_ack) begin
               if (color_line) begin
                  state_nxt = RD_P1;
               end else begin
                  fill_now  = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         RD_P1: begin
            o_rd_req  = 1'b1;
            o_rd_addr = {5'd1, vaddr_r};
            if (i_rd_ack) begin
               fill_now  = 1'b1;
               fill_pix  = p0_r;
               fill_attr = i_rd_data;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Fetch address latch, plane-0 holding byte and the one-group buffer
   always_ff @(posedge i_clk) begin
      if (!reset_n) begin
         vaddr_r  <= 16'd0;
         p0_r     <= 8'h00;
         buf_full <= 1'b0;
         buf_pix  <= 8'h00;
         buf_attr <= 8'h00;
      end else begin
         if (fetch_start) vaddr_r <= vaddr_calc;
         if ((state == RD_P0) && i_rd_ack) p0_r <= i_rd_data;
         if (grp_load) begin
            buf_full <= 1'b0;
         end else if (fill_now) begin
            buf_full <= 1'b1;
            buf_pix  <= fill_pix;
            buf_attr <= fill_attr;
         end
      end
   end

   // Fetch pointer and per-line settings, re-armed at the end of active video
   always_ff @(posedge i_clk) begin
      if (!reset_n) begin
         fcol       <= 6'd0;
         frow       <= 8'd0;
         fetch_en   <= 1'b0;
         primed     <= 1'b0;
         scr_line   <= 2'd0;
         color_line <= 1'b0;
      end else if (at_ha) begin
         fcol       <= 6'd0;
         frow       <= v_nxt[7:0];
         fetch_en   <= (v_nxt < VA_W);
         primed     <= 1'b1;
         scr_line   <= i_scr_sel;
         color_line <= i_color_mode;
      end else if (fill_now) begin
         fcol <= fcol + 6'd1;
      end
   end

   // Group source: a fill arriving in the load cycle takes priority
   always_comb begin
      ld_pix  = 8'h00;
      ld_attr = 8'h00;
      if (fill_now) begin
         ld_pix  = fill_pix;
         ld_attr = fill_attr;
      end else if (buf_full) begin
         ld_pix  = buf_pix;
         ld_attr = buf_attr;
      end
      cur_byte = grp_load ? ld_pix  : shreg;
      cur_attr = grp_load ? ld_attr : attr_r;
      if (color_line) pix_val = cur_byte[7] ? cur_attr[3:0] : cur_attr[7:4];
      else            pix_val = {4{cur_byte[7]}};
   end

`ifdef ORION_VIDEO_BORDER_EN
   logic [3:0] border_r;
   assign border_val = (h == 10'd0) ? i_border : border_r;

   // Border colour held for the whole line
   always_ff @(posedge i_clk) begin
      if (!reset_n)                        border_r <= 4'h0;
      else if (i_pix_ce && (h == 10'd0))   border_r <= i_border;
   end
`else
   assign border_val = 4'h0;
`endif

   // Raster counters, registered raster outputs and pixel shifter
   always_ff @(posedge i_clk) begin
      if (!reset_n) begin
         h           <= 10'd0;
         v           <= 9'd0;
         o_de        <= 1'b0;
         o_hsync     <= 1'b0;
         o_vsync     <= 1'b0;
         o_pix       <= 4'h0;
         o_frame_end <= 1'b0;
         o_underrun  <= 1'b0;
         shreg       <= 8'h00;
         attr_r      <= 8'h00;
      end else begin
         o_frame_end <= i_pix_ce && (h == HT_LAST) && (v == VA_LAST);
         if (grp_load && !fill_now && !buf_full) o_underrun <= 1'b1;
         if (i_pix_ce) begin
            o_de    <= de_now;
            o_hsync <= hs_now;
            o_vsync <= vs_now;
            o_pix   <= de_now ? pix_val : border_val;
            shreg   <= {cur_byte[6:0], 1'b0};
            attr_r  <= cur_attr;
            if (h == HT_LAST) begin
               h <= 10'd0;
               v <= v_nxt;
            end else begin
               h <= h + 10'd1;
            end
         end
      end
   end
endmodule
